led_sequencer: RTL and testbench

//  Plays a programmable pattern of up to NUM_STEPS {rgb, duration} steps through a

---
 rtl/led_seq_pkg.sv | 28 ++
 rtl/led_step_table.sv | 39 +++
 rtl/led_sequencer.sv | 162 ++++++++++++++++
 tb/tb_led_sequencer.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and colour constants for the LED pattern sequencer.
// step_t describes one table entry at the default duration width.
package led_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_LOAD = 3'd1,
      S_FIRE = 3'd2,
      S_WAIT = 3'd3,
      S_GAP  = 3'd4
   } seq_state_e;

   typedef logic [2:0] rgb_t;

   localparam rgb_t RGB_OFF   = 3'b000;
   localparam rgb_t RGB_RED   = 3'b100;
   localparam rgb_t RGB_GREEN = 3'b010;
   localparam rgb_t RGB_BLUE  = 3'b001;
   localparam rgb_t RGB_WHITE = 3'b111;

   localparam int DUR_WIDTH_DEF = 27;

   typedef struct packed {
      rgb_t                     rgb;
      logic [DUR_WIDTH_DEF-1:0] dur;
   } step_t;

endpackage

// File: rtl/led_step_table.sv
// Pattern table: NUM_STEPS {rgb, duration} entries, one write port and a
// combinational read port. All entries clear to {0,0} on reset.
module led_step_table
   import led_seq_pkg::*;
#(
   parameter  int NUM_STEPS = 8,
   parameter  int DUR_WIDTH = 27,
   localparam int ADDR_W    = $clog2(NUM_STEPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 we_i,
   input  logic [ADDR_W-1:0]    waddr_i,
   input  rgb_t                 wrgb_i,
   input  logic [DUR_WIDTH-1:0] wdur_i,
   input  logic [ADDR_W-1:0]    raddr_i,
   output rgb_t                 rrgb_o,
   output logic [DUR_WIDTH-1:0] rdur_o
);

   rgb_t                 rgb_q [NUM_STEPS];
   logic [DUR_WIDTH-1:0] dur_q [NUM_STEPS];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_STEPS; i++) begin
            rgb_q[i] <= RGB_OFF;
            dur_q[i] <= '0;
         end
      end else if (we_i) begin
         rgb_q[waddr_i] <= wrgb_i;
         dur_q[waddr_i] <= wdur_i;
      end
   end

   assign rrgb_o = rgb_q[raddr_i];
   assign rdur_o = dur_q[raddr_i];

endmodule

// File: rtl/led_sequencer.sv
// Plays the step table through a downstream led_controller: load a step,
// pulse start, wait for trigger_next, optional gap, then advance or finish.
module led_sequencer
   import led_seq_pkg::*;
#(
   parameter  int NUM_STEPS  = 8,
   parameter  int DUR_WIDTH  = DUR_WIDTH_DEF,
   parameter  int GAP_CYCLES = 0,
   localparam int ADDR_W     = $clog2(NUM_STEPS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 cfg_we,
   input  logic [ADDR_W-1:0]    cfg_addr,
   input  rgb_t                 cfg_rgb,
   input  logic [DUR_WIDTH-1:0] cfg_dur,
   input  logic [ADDR_W-1:0]    cfg_last,
   input  logic                 loop,
   input  logic                 go,
   input  logic                 stop,
   output logic                 busy,
   output logic [ADDR_W-1:0]    step_idx,
   output logic                 done,
   output rgb_t                 ctrl_rgb,
   output logic [DUR_WIDTH-1:0] ctrl_pulse_cycles,
   output logic                 ctrl_start,
   output logic                 ctrl_abort,
   input  logic                 ctrl_trigger_next,
   output seq_state_e           dbg_state
);

   localparam bit HAS_GAP = (GAP_CYCLES > 0);

   seq_state_e           state_q;
   logic [ADDR_W-1:0]    step_idx_q, last_q;
   logic                 busy_q, done_q, ctrl_start_q, ctrl_abort_q;
   rgb_t                 ctrl_rgb_q;
   logic [DUR_WIDTH-1:0] ctrl_pc_q;

   rgb_t                 tbl_rgb;
   logic [DUR_WIDTH-1:0] tbl_dur;
   logic                 at_last, gap_go, gap_last, adv_d;
   logic [ADDR_W-1:0]    adv_idx_d;

   led_step_table #(
      .NUM_STEPS (NUM_STEPS),
      .DUR_WIDTH (DUR_WIDTH)
   ) u_table (
      .clk     (clk),
      .rst     (rst),
      .we_i    (cfg_we),
      .waddr_i (cfg_addr),
      .wrgb_i  (cfg_rgb),
      .wdur_i  (cfg_dur),
      .raddr_i (step_idx_q),
      .rrgb_o  (tbl_rgb),
      .rdur_o  (tbl_dur)
   );

   assign at_last   = (step_idx_q == last_q);
   assign gap_go    = HAS_GAP && (!at_last || loop);
   assign adv_idx_d = at_last ? '0 : step_idx_q + ADDR_W'(1);

   if (HAS_GAP) begin : g_gap
      localparam int GAP_W = $clog2(GAP_CYCLES + 1);
      logic [GAP_W-1:0] gap_cnt_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst)                  gap_cnt_q <= '0;
         else if (state_q == S_GAP) gap_cnt_q <= gap_cnt_q + GAP_W'(1);
         else                      gap_cnt_q <= '0;
      end

      assign gap_last = (gap_cnt_q == GAP_W'(GAP_CYCLES - 1));
   end else begin : g_no_gap
      assign gap_last = 1'b0;
   end

   // Advance decision: leave the current step this edge (skip, trigger, or gap end).
   always_comb begin
      adv_d = 1'b0;
      case (state_q)
         S_LOAD:  adv_d = (tbl_dur == '0);
         S_WAIT:  adv_d = ctrl_trigger_next && !gap_go;
         S_GAP:   adv_d = gap_last;
         default: adv_d = 1'b0;
      endcase
   end

   // Controller handshake: ctrl_start is a one-cycle request with rgb/pulse_cycles
   // held stable from LOAD through WAIT; trigger_next is honoured only in WAIT.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         step_idx_q   <= '0;
         last_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ctrl_start_q <= 1'b0;
         ctrl_abort_q <= 1'b0;
         ctrl_rgb_q   <= RGB_OFF;
         ctrl_pc_q    <= '0;
      end else begin
         ctrl_start_q <= 1'b0;
         ctrl_abort_q <= 1'b0;
         done_q       <= 1'b0;
         if (stop && state_q != S_IDLE) begin
            state_q      <= S_IDLE;
            busy_q       <= 1'b0;
            ctrl_abort_q <= 1'b1;
            ctrl_rgb_q   <= RGB_OFF;
            ctrl_pc_q    <= '0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (go && !stop) begin
                     state_q    <= S_LOAD;
                     busy_q     <= 1'b1;
                     step_idx_q <= '0;
                     last_q     <= cfg_last;
                  end
               end
               S_LOAD: begin
                  ctrl_rgb_q <= tbl_rgb;
                  ctrl_pc_q  <= tbl_dur;
                  if (tbl_dur != '0) state_q <= S_FIRE;
               end
               S_FIRE: begin
                  ctrl_start_q <= 1'b1;
                  state_q      <= S_WAIT;
               end
               S_WAIT: begin
                  if (ctrl_trigger_next && gap_go) state_q <= S_GAP;
               end
               S_GAP: begin
               end
               default: state_q <= S_IDLE;
            endcase
            if (adv_d) begin
               if (at_last && !loop) begin
                  state_q <= S_IDLE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end else begin
                  state_q    <= S_LOAD;
                  step_idx_q <= adv_idx_d;
               end
            end
         end
      end
   end

   assign busy              = busy_q;
   assign step_idx          = step_idx_q;
   assign done              = done_q;
   assign ctrl_rgb          = ctrl_rgb_q;
   assign ctrl_pulse_cycles = ctrl_pc_q;
   assign ctrl_start        = ctrl_start_q;
   assign ctrl_abort        = ctrl_abort_q;
   assign dbg_state         = state_q;

endmodule

// File: tb/tb_led_sequencer.sv
// Bench for led_sequencer: two instances (no gap and a 3-cycle gap) share the
// stimulus; each has its own controller model and start/done timing checks.
module tb_led_sequencer;
   import led_seq_pkg::*;

   localparam int NS = 8;
   localparam int AW = 3;
   localparam int DW = 27;
   localparam int EW = 4 + 3 + DW;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_we = 1'b0;
   logic [AW-1:0] cfg_addr = '0;
   rgb_t          cfg_rgb = RGB_OFF;
   logic [DW-1:0] cfg_dur = '0;
   logic [AW-1:0] cfg_last = '0;
   logic          loop = 1'b0;
   logic          go = 1'b0;
   logic          stop = 1'b0;

   logic [1:0]    busy, done, ctrl_start, ctrl_abort;
   logic [1:0]    trig = 2'b00;
   logic [AW-1:0] step_idx [2];
   rgb_t          ctrl_rgb [2];
   logic [DW-1:0] ctrl_pc [2];
   seq_state_e    dbg_state [2];

   // clock / reset
   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      led_sequencer #(
         .NUM_STEPS  (NS),
         .DUR_WIDTH  (DW),
         .GAP_CYCLES (3 * g)
      ) dut (
         .clk               (clk),
         .rst               (rst),
         .cfg_we            (cfg_we),
         .cfg_addr          (cfg_addr),
         .cfg_rgb           (cfg_rgb),
         .cfg_dur           (cfg_dur),
         .cfg_last          (cfg_last),
         .loop              (loop),
         .go                (go),
         .stop              (stop),
         .busy              (busy[g]),
         .step_idx          (step_idx[g]),
         .done              (done[g]),
         .ctrl_rgb          (ctrl_rgb[g]),
         .ctrl_pulse_cycles (ctrl_pc[g]),
         .ctrl_start        (ctrl_start[g]),
         .ctrl_abort        (ctrl_abort[g]),
         .ctrl_trigger_next (trig[g]),
         .dbg_state         (dbg_state[g])
      );
   end

   // scoreboard state: exp_q items are {skips_before, rgb, dur}
   int            n_checks = 0;
   int            n_errors = 0;
   int            cyc = 0;
   logic [EW-1:0] exp_q[$];
   int            exp_trail = 0;
   int            rd [2];
   int            start_tot [2];
   int            done_cnt [2];
   int            abort_cnt [2];
   int            rem [2];
   int            exp_start [2];
   int            exp_done [2];
   logic [EW-1:0] mon_item;
   rgb_t          tab_rgb [NS];
   logic [DW-1:0] tab_dur [NS];

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // controller model + monitor, sampled 1 time unit after each rising edge
   always begin
      @(posedge clk);
      cyc = cyc + 1;
      #1;
      for (int g = 0; g < 2; g++) begin
         trig[g] = 1'b0;
         if (ctrl_abort[g]) abort_cnt[g]++;
         if (rst || ctrl_abort[g]) begin
            rem[g] = 0;
         end else if (rem[g] > 0) begin
            rem[g]--;
            if (rem[g] == 0) begin
               trig[g] = 1'b1;
               if (rd[g] < exp_q.size()) begin
                  mon_item = exp_q[rd[g]];
                  exp_start[g] = cyc + 1 + 2 + 3 * g + int'(mon_item[EW-1 -: 4]);
               end else begin
                  exp_done[g] = cyc + 1 + ((exp_trail > 0) ? 3 * g + exp_trail : 0);
               end
            end
         end
         if (ctrl_start[g]) begin
            start_tot[g]++;
            rem[g] = int'(ctrl_pc[g]);
            if (rd[g] < exp_q.size()) begin
               mon_item = exp_q[rd[g]];
               check("start_rgb", 64'(ctrl_rgb[g]), 64'(mon_item[DW +: 3]));
               check("start_dur", 64'(ctrl_pc[g]), 64'(mon_item[DW-1:0]));
               check("start_cyc", 64'(cyc), 64'(exp_start[g]));
               rd[g]++;
            end else begin
               check("extra_start", 64'(start_tot[g]), 64'(exp_q.size()));
            end
         end
         if (done[g]) begin
            done_cnt[g]++;
            check("done_cyc", 64'(cyc), 64'(exp_done[g]));
            check("done_busy", 64'(busy[g]), 64'd0);
            check("done_all_starts", 64'(rd[g]), 64'(exp_q.size()));
         end
      end
   end

   // driver tasks
   task automatic write_step(input int a, input rgb_t r, input int d);
      @(negedge clk);
      cfg_we   = 1'b1;
      cfg_addr = AW'(a);
      cfg_rgb  = r;
      cfg_dur  = DW'(d);
      tab_rgb[a] = r;
      tab_dur[a] = DW'(d);
      @(negedge clk);
      cfg_we = 1'b0;
   endtask

   task automatic clear_sb();
      exp_q.delete();
      exp_trail = 0;
      for (int g = 0; g < 2; g++) begin
         rd[g] = 0; start_tot[g] = 0; done_cnt[g] = 0; abort_cnt[g] = 0;
         exp_start[g] = -1; exp_done[g] = -1;
      end
   endtask

   // reference: steps 0..last in order, zero-duration steps contribute no start
   task automatic build_expect(input int last);
      int skips = 0;
      for (int i = 0; i <= last; i++) begin
         if (tab_dur[i] == '0) skips++;
         else begin
            exp_q.push_back({4'(skips), tab_rgb[i], tab_dur[i]});
            skips = 0;
         end
      end
      exp_trail = skips;
   endtask

   task automatic play(input int last, input logic lp);
      logic [EW-1:0] it;
      cfg_last = AW'(last);
      loop     = lp;
      @(negedge clk);
      go = 1'b1;
      for (int g = 0; g < 2; g++) begin
         if (exp_q.size() > 0) begin
            it = exp_q[0];
            exp_start[g] = cyc + 1 + 2 + int'(it[EW-1 -: 4]);
         end else begin
            exp_done[g] = cyc + 1 + exp_trail;
         end
      end
      @(negedge clk);
      go = 1'b0;
   endtask

   task automatic wait_done(input int limit);
      for (int i = 0; i < limit && !(done_cnt[0] > 0 && done_cnt[1] > 0); i++) @(negedge clk);
      repeat (6) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("done_once", 64'(done_cnt[g]), 64'd1);
         check("starts_total", 64'(start_tot[g]), 64'(exp_q.size()));
         check("idle_after", 64'(busy[g]), 64'd0);
      end
   endtask

   task automatic wait_start1(input int n, input int limit);
      for (int i = 0; i < limit && start_tot[1] < n; i++) @(negedge clk);
      check("wait_start", 64'(start_tot[1]), 64'(n));
   endtask

   task automatic check_all_zero(input string tag);
      for (int g = 0; g < 2; g++) begin
         check({tag, "_busy"}, 64'(busy[g]), 64'd0);
         check({tag, "_done"}, 64'(done[g]), 64'd0);
         check({tag, "_start"}, 64'(ctrl_start[g]), 64'd0);
         check({tag, "_abort"}, 64'(ctrl_abort[g]), 64'd0);
         check({tag, "_rgb"}, 64'(ctrl_rgb[g]), 64'd0);
         check({tag, "_pc"}, 64'(ctrl_pc[g]), 64'd0);
         check({tag, "_idx"}, 64'(step_idx[g]), 64'd0);
         check({tag, "_state"}, 64'(dbg_state[g]), 64'(S_IDLE));
      end
   endtask

   initial begin
      for (int i = 0; i < NS; i++) begin
         tab_rgb[i] = RGB_OFF;
         tab_dur[i] = '0;
      end
      clear_sb();
      for (int g = 0; g < 2; g++) rem[g] = 0;

      repeat (3) @(negedge clk);
      check_all_zero("reset");
      rst = 1'b0;
      repeat (2) @(negedge clk);
      check_all_zero("post_reset");

      // three-step single playback, with a go while busy
      write_step(0, RGB_RED, 10);
      write_step(1, RGB_GREEN, 4);
      write_step(2, RGB_BLUE, 6);
      clear_sb();
      build_expect(2);
      play(2, 1'b0);
      wait_start1(1, 20);
      @(negedge clk); go = 1'b1;
      @(negedge clk); go = 1'b0;
      wait_done(200);

      // zero-duration step skipped
      write_step(1, RGB_GREEN, 0);
      clear_sb();
      build_expect(2);
      play(2, 1'b0);
      wait_done(200);

      // looping two-step pattern, loop cleared during the second pass of step 0
      write_step(0, RGB_RED, 20);
      write_step(1, RGB_GREEN, 4);
      clear_sb();
      build_expect(1);
      build_expect(1);
      play(1, 1'b1);
      wait_start1(3, 200);
      @(negedge clk); loop = 1'b0;
      wait_done(300);

      // stop during WAIT
      write_step(0, RGB_WHITE, 40);
      clear_sb();
      build_expect(0);
      play(0, 1'b0);
      wait_start1(1, 20);
      repeat (3) @(negedge clk);
      stop = 1'b1;
      @(posedge clk); #1;
      stop = 1'b0;
      for (int g = 0; g < 2; g++) begin
         check("stop_busy", 64'(busy[g]), 64'd0);
         check("stop_abort", 64'(ctrl_abort[g]), 64'd1);
         check("stop_start", 64'(ctrl_start[g]), 64'd0);
         check("stop_done", 64'(done[g]), 64'd0);
         check("stop_rgb", 64'(ctrl_rgb[g]), 64'd0);
         check("stop_pc", 64'(ctrl_pc[g]), 64'd0);
      end
      @(posedge clk); #1;
      for (int g = 0; g < 2; g++) check("abort_pulse", 64'(ctrl_abort[g]), 64'd0);
      repeat (50) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("stop_no_start", 64'(start_tot[g]), 64'(exp_q.size()));
         check("stop_no_done", 64'(done_cnt[g]), 64'd0);
      end
      @(negedge clk); go = 1'b1; stop = 1'b1;
      @(negedge clk); go = 1'b0; stop = 1'b0;
      repeat (20) @(negedge clk);
      for (int g = 0; g < 2; g++) begin
         check("gostop_busy", 64'(busy[g]), 64'd0);
         check("gostop_no_start", 64'(start_tot[g]), 64'(exp_q.size()));
         check("abort_count", 64'(abort_cnt[g]), 64'd1);
      end

      // asynchronous reset mid-WAIT clears outputs and the table
      write_step(0, RGB_BLUE, 30);
      clear_sb();
      build_expect(0);
      play(0, 1'b0);
      wait_start1(1, 20);
      repeat (2) @(negedge clk);
      @(posedge clk); #3;
      rst = 1'b1;
      #1;
      check_all_zero("async_rst");
      repeat (2) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < NS; i++) begin
         tab_rgb[i] = RGB_OFF;
         tab_dur[i] = '0;
      end
      clear_sb();
      build_expect(3);
      play(3, 1'b0);
      wait_done(50);

      // randomized tables
      for (int t = 0; t < 6; t++) begin
         int last;
         for (int i = 0; i < NS; i++)
            write_step(i, rgb_t'($urandom_range(0, 7)),
                       ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, 6)));
         last = int'($urandom_range(0, NS - 1));
         clear_sb();
         build_expect(last);
         play(last, 1'b0);
         wait_done(400);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
